// File: rtl/pipe_beat_deserializer_pkg.sv
// Shared definitions for the beat-link receive path: header layout, pipe tags, FSM states.
package pipe_beat_deserializer_pkg;

   localparam int BEAT_WIDTH    = 32;
   localparam int DEF_MSG_WIDTH = 192;

   localparam int TAG_MSB = 31;
   localparam int TAG_LSB = 16;
   localparam int LEN_MSB = 15;
   localparam int LEN_LSB = 0;

   localparam logic [15:0] TAG_HEARD = 16'd1;
   localparam logic [15:0] TAG_SAY   = 16'd1;
   localparam logic [15:0] TAG_SAY2  = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BODY,
      ST_DISCARD,
      ST_DELIVER
   } deser_state_e;

endpackage

// File: rtl/pipe_beat_deserializer_buf.sv
// One message holding register: clear, word-indexed write and a valid flag.
// Clear and write in the same cycle leave only the written word non-zero.
module pipe_deser_buf
   import pipe_beat_deserializer_pkg::*;
#(
   parameter int MSG_WIDTH = DEF_MSG_WIDTH,
   parameter int IW        = $clog2(MSG_WIDTH / BEAT_WIDTH)
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  clr_i,
   input  logic                  wr_i,
   input  logic [IW-1:0]         widx_i,
   input  logic [BEAT_WIDTH-1:0] wdat_i,
   input  logic                  set_vld_i,
   input  logic                  clr_vld_i,
   output logic [MSG_WIDTH-1:0]  dat_o,
   output logic                  vld_o
);
   localparam int NWORDS = MSG_WIDTH / BEAT_WIDTH;

   logic [NWORDS-1:0][BEAT_WIDTH-1:0] dat_q, dat_d;
   logic                              vld_q, vld_d;

   always_comb begin
      dat_d = dat_q;
      if (clr_i)
         dat_d = '0;
      if (wr_i && (int'(widx_i) < NWORDS))
         dat_d[widx_i] = wdat_i;

      vld_d = vld_q;
      if (set_vld_i)
         vld_d = 1'b1;
      else if (clr_vld_i)
         vld_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         dat_q <= '0;
         vld_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         vld_q <= vld_d;
      end
   end

   assign dat_o = dat_q;
   assign vld_o = vld_q;

endmodule

// File: rtl/pipe_beat_deserializer.sv
// Beat-link receiver: reassembles header + payload beats into one tagged pipe message.
// PIPE_DESER_DBUF_EN adds a second ping-pong buffer so assembly overlaps delivery.
module pipe_beat_deserializer
   import pipe_beat_deserializer_pkg::*;
#(
   parameter int MSG_WIDTH = DEF_MSG_WIDTH
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  beat_enq__ENA,
   input  logic [BEAT_WIDTH-1:0] beat_enq_v,
   output logic                  beat_enq__RDY,
   output logic                  pipe_enq__ENA,
   output logic [MSG_WIDTH-1:0]  pipe_enq_v,
   input  logic                  pipe_enq__RDY,
   output logic [15:0]           err_count
);
   localparam int NWORDS      = MSG_WIDTH / BEAT_WIDTH;
   localparam int MAX_PAYLOAD = NWORDS - 1;
   localparam int IW          = $clog2(NWORDS);
`ifdef PIPE_DESER_DBUF_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif

   deser_state_e state_q, state_d;
   logic [15:0]  len_q, len_d;
   logic [15:0]  rem_q, rem_d;
   logic [15:0]  err_q, err_d;
   logic         wr_sel_q, wr_sel_d;
   logic         rd_sel_q, rd_sel_d;

   logic                  beat_fire, pipe_fire, msg_vld;
   logic                  hdr_wr, pay_wr, complete, err_inc;
   logic                  nxt_sel, nxt_busy;
   logic [15:0]           hdr_len;
   logic [IW-1:0]         widx;
   logic [BEAT_WIDTH-1:0] wdat;

   logic [NBUF-1:0]       b_vld;
   logic [MSG_WIDTH-1:0]  b_dat [NBUF];

   assign beat_enq__RDY = (state_q != ST_DELIVER);
   assign beat_fire     = beat_enq__ENA && beat_enq__RDY;
   assign msg_vld       = b_vld[rd_sel_q];
   assign pipe_enq__ENA = msg_vld && pipe_enq__RDY;
   assign pipe_fire     = pipe_enq__ENA;
   assign pipe_enq_v    = b_dat[rd_sel_q];
   assign err_count     = err_q;

   assign hdr_len = beat_enq_v[LEN_MSB:LEN_LSB];

   // Payload beat k goes to word k+1; word 0 carries the zero-extended tag.
   assign widx = hdr_wr ? '0 : IW'(len_q - rem_q + 16'd1);
   assign wdat = hdr_wr ? {16'b0, beat_enq_v[TAG_MSB:TAG_LSB]} : beat_enq_v;

   // A finished message may only release the assembler if the next buffer is free.
   assign nxt_sel  = (NBUF > 1) ? ~wr_sel_q : wr_sel_q;
   assign nxt_busy = (nxt_sel == wr_sel_q) ||
                     (b_vld[nxt_sel] && !(pipe_fire && (rd_sel_q == nxt_sel)));

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rem_d    = rem_q;
      wr_sel_d = wr_sel_q;
      hdr_wr   = 1'b0;
      pay_wr   = 1'b0;
      complete = 1'b0;
      err_inc  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (beat_fire) begin
               hdr_wr = 1'b1;
               len_d  = hdr_len;
               rem_d  = hdr_len;
               if (hdr_len == 16'd0) begin
                  complete = 1'b1;
               end else if (hdr_len <= 16'(MAX_PAYLOAD)) begin
                  state_d = ST_BODY;
               end else begin
                  state_d = ST_DISCARD;
                  err_inc = 1'b1;
               end
            end
         end
         ST_BODY: begin
            if (beat_fire) begin
               pay_wr = 1'b1;
               rem_d  = rem_q - 16'd1;
               if (rem_q == 16'd1)
                  complete = 1'b1;
            end
         end
         ST_DISCARD: begin
            if (beat_fire) begin
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1)
                  state_d = ST_IDLE;
            end
         end
         ST_DELIVER: begin
            if (pipe_fire)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (complete) begin
         wr_sel_d = nxt_sel;
         state_d  = nxt_busy ? ST_DELIVER : ST_IDLE;
      end
   end

   always_comb begin
      rd_sel_d = rd_sel_q;
      if (pipe_fire && (NBUF > 1))
         rd_sel_d = ~rd_sel_q;

      err_d = err_q;
      if (err_inc && (err_q != 16'hFFFF))
         err_d = err_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         rem_q    <= '0;
         err_q    <= '0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         rem_q    <= rem_d;
         err_q    <= err_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   for (genvar i = 0; i < NBUF; i++) begin : g_buf
      logic sel_w, sel_r;
      assign sel_w = (wr_sel_q == 1'(i));
      assign sel_r = (rd_sel_q == 1'(i));

      pipe_deser_buf #(
         .MSG_WIDTH (MSG_WIDTH),
         .IW        (IW)
      ) u_buf (
         .CLK       (CLK),
         .nRST      (nRST),
         .clr_i     (hdr_wr && sel_w),
         .wr_i      ((hdr_wr || pay_wr) && sel_w),
         .widx_i    (widx),
         .wdat_i    (wdat),
         .set_vld_i (complete && sel_w),
         .clr_vld_i (pipe_fire && sel_r),
         .dat_o     (b_dat[i]),
         .vld_o     (b_vld[i])
      );
   end

endmodule

// File: tb/tb_pipe_beat_deserializer.sv
// Scoreboard bench for pipe_beat_deserializer: directed messages, monitor pops on each transfer.
`timescale 1ns/1ps
module tb_pipe_beat_deserializer;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         beat_ena = 1'b0;
   logic [31:0]  beat_v = '0;
   logic         beat_rdy;
   logic         pipe_ena;
   logic [191:0] pipe_v;
   logic         pipe_rdy = 1'b1;
   logic [15:0]  err_cnt;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      logic [191:0] msg;
      int           cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] pl[8];
   int          gp[8];

   pipe_beat_deserializer dut (
      .CLK           (clk),
      .nRST          (nrst),
      .beat_enq__ENA (beat_ena),
      .beat_enq_v    (beat_v),
      .beat_enq__RDY (beat_rdy),
      .pipe_enq__ENA (pipe_ena),
      .pipe_enq_v    (pipe_v),
      .pipe_enq__RDY (pipe_rdy),
      .err_count     (err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nrst && pipe_ena) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_xfer: got message %0h, want no transfer", pipe_v);
         end else begin
            mon_e = sb.pop_front();
            chk("xfer_data", pipe_v, mon_e.msg);
            if (mon_e.cyc >= 0)
               chk("xfer_cycle", 192'(cyc), 192'(mon_e.cyc));
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, output int acc);
      int t;
      t = 0;
      @(negedge clk);
      while (!beat_rdy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!beat_rdy) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_rdy_timeout: got rdy 0, want 1");
      end
      beat_ena = 1'b1;
      beat_v   = d;
      acc      = cyc;
      @(posedge clk);
      #1;
      beat_ena = 1'b0;
   endtask

   task automatic send_msg(input logic [31:0] hdr, input int n, output int c_hdr, output int c_last);
      int a;
      send_beat(hdr, c_hdr);
      c_last = c_hdr;
      for (int k = 0; k < n; k++) begin
         if (gp[k] > 0) begin
            repeat (gp[k]) @(posedge clk);
            #1;
         end
         send_beat(pl[k], a);
         c_last = a;
      end
   endtask

   function automatic logic [191:0] model(input logic [31:0] hdr, input int n);
      logic [191:0] m;
      m = '0;
      m[31:0] = {16'h0, hdr[31:16]};
      for (int k = 0; k < n; k++)
         m[32*(k+1) +: 32] = pl[k];
      return m;
   endfunction

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(name, 192'(sb.size()), 192'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      int ch, cl;
      logic [191:0] exp_a;
      for (int k = 0; k < 8; k++) begin
         gp[k] = 0;
         pl[k] = '0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_beat_rdy", 192'(beat_rdy), 192'(1));
      chk("rst_pipe_ena", 192'(pipe_ena), 192'(0));
      chk("rst_pipe_v", pipe_v, 192'(0));
      chk("rst_err", 192'(err_cnt), 192'(0));
      @(posedge clk);
      #1;
      nrst = 1'b1;

      // Basic two-beat message, back-to-back.
      pl[0] = 32'h11;
      pl[1] = 32'h22;
      exp_a = {96'h0, 32'h22, 32'h11, 32'h1};
      send_msg(32'h0001_0002, 2, ch, cl);
      sb.push_back('{exp_a, ch + 3});
      drain("basic_one_xfer");

      // Downstream stall.
      pipe_rdy = 1'b0;
      send_msg(32'h0001_0002, 2, ch, cl);
      sb.push_back('{exp_a, -1});
`ifdef PIPE_DESER_DBUF_EN
      pl[0] = 32'h33;
      send_msg(32'h0002_0001, 1, ch, cl);
      sb.push_back('{{128'h0, 32'h33, 32'h2}, -1});
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ena", 192'(pipe_ena), 192'(0));
         chk("stall_data", pipe_v, exp_a);
         chk("stall_beat_rdy", 192'(beat_rdy), 192'(0));
      end
      @(posedge clk);
      #1;
      pipe_rdy = 1'b1;
      drain("stall_release");

      // Zero-length message, then a message whose header must be the next beat.
      send_msg(32'h0002_0000, 0, ch, cl);
      sb.push_back('{{160'h0, 32'h2}, ch + 1});
      pl[0] = 32'h44;
      send_msg(32'h0001_0001, 1, ch, cl);
      sb.push_back('{{128'h0, 32'h44, 32'h1}, cl + 1});
      drain("zero_len");

      // Oversize message is dropped and counted.
      for (int k = 0; k < 7; k++)
         pl[k] = 32'hB0 + 32'(k);
      send_msg(32'h0001_0007, 7, ch, cl);
      @(negedge clk);
      chk("oversize_err", 192'(err_cnt), 192'(1));
      pl[0] = 32'hAA;
      pl[1] = 32'hBB;
      send_msg(32'h0002_0002, 2, ch, cl);
      sb.push_back('{model(32'h0002_0002, 2), cl + 1});
      drain("after_oversize");
      chk("oversize_err_hold", 192'(err_cnt), 192'(1));

      // Reset in the middle of a message.
      pl[0] = 32'h55;
      send_msg(32'h0003_0003, 1, ch, cl);
      nrst = 1'b0;
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(negedge clk);
      chk("midrst_err", 192'(err_cnt), 192'(0));
      chk("midrst_rdy", 192'(beat_rdy), 192'(1));
      pl[0] = 32'h66;
      send_msg(32'h0004_0001, 1, ch, cl);
      sb.push_back('{{128'h0, 32'h66, 32'h4}, cl + 1});
      drain("midrst_next");

      // Idle gaps between payload beats.
      pl[0] = 32'h11;
      pl[1] = 32'h22;
      gp[0] = 1;
      gp[1] = 3;
      send_msg(32'h0001_0002, 2, ch, cl);
      sb.push_back('{exp_a, cl + 1});
      drain("gaps");
      gp[0] = 0;
      gp[1] = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
